// File: rtl/sync_pattern_pkg.sv
// Shared types and constants for the sync-pattern serializer.
package sync_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    PAR
  } state_e;

  localparam logic [3:0] DEFAULT_SYNC_PAT = 4'b1011;

  // Clock cycles occupied by one frame on the line.
  function automatic int unsigned frame_cycles(input int unsigned sync_w,
                                               input int unsigned data_w,
                                               input int unsigned parity,
                                               input int unsigned bit_cycles);
    return (sync_w + data_w + parity) * bit_cycles;
  endfunction

endpackage

// File: rtl/sync_pattern_bit_timer.sv
// Counts BIT_CYCLES clocks per line bit; flags first and last cycle of each bit.
module sync_pattern_bit_timer #(
  parameter int unsigned BIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic tick,
  output logic first
);

  localparam int unsigned CW = $clog2(BIT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = en && (cnt_q == LAST);
  assign first = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sync_pattern_serializer.sv
// Frames a payload word as SYNC_PAT + payload (+ even parity) on a 1-bit line.
// Define SYNC_PATTERN_PARITY_EN to append the parity bit (state PAR).
module sync_pattern_serializer
  import sync_pattern_pkg::*;
#(
  parameter int unsigned       SYNC_W     = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = DEFAULT_SYNC_PAT,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       BIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              out,
  output logic              bit_start,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned FW = SYNC_W + DATA_W;
  localparam int unsigned BW = $clog2(SYNC_W + DATA_W + 1) + 1;
  localparam logic [BW-1:0] LAST_SYNC = BW'(SYNC_W - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          out_q, out_d;
  logic          data_ready_q, data_ready_d;
  logic          accept;
  logic          tick;
  logic          first;
  logic          frame_done_c;
`ifdef SYNC_PATTERN_PARITY_EN
  logic          par_q, par_d;
`endif

  sync_pattern_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .start(accept),
    .en   (state_q != IDLE),
    .tick (tick),
    .first(first)
  );

  // Sync pattern and payload share one shift register; its MSB is the current line bit.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    frame_d      = frame_q;
    accept       = 1'b0;
    frame_done_c = 1'b0;
`ifdef SYNC_PATTERN_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_valid && data_ready_q) begin
          accept    = 1'b1;
          state_d   = SYNC;
          bit_cnt_d = '0;
          frame_d   = {SYNC_PAT, data_in};
`ifdef SYNC_PATTERN_PARITY_EN
          par_d     = ^data_in;
`endif
        end
      end
      SYNC: begin
        if (tick) begin
          frame_d = {frame_q[FW-2:0], 1'b0};
          if (bit_cnt_q == LAST_SYNC) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          frame_d = {frame_q[FW-2:0], 1'b0};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef SYNC_PATTERN_PARITY_EN
            state_d   = PAR;
`else
            state_d      = IDLE;
            frame_done_c = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef SYNC_PATTERN_PARITY_EN
      PAR: begin
        if (tick) begin
          state_d      = IDLE;
          frame_done_c = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Line level is computed from the next state so that out is a plain flop.
    case (state_d)
      SYNC, DATA: out_d = frame_d[FW-1];
`ifdef SYNC_PATTERN_PARITY_EN
      PAR:        out_d = par_d;
`endif
      default:    out_d = 1'b0;
    endcase
    data_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      frame_q      <= '0;
      out_q        <= 1'b0;
      data_ready_q <= 1'b0;
`ifdef SYNC_PATTERN_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_q      <= frame_d;
      out_q        <= out_d;
      data_ready_q <= data_ready_d;
`ifdef SYNC_PATTERN_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign out        = out_q;
  assign data_ready = data_ready_q;
  assign busy       = (state_q != IDLE);
  assign bit_start  = first;
  assign frame_done = frame_done_c;

endmodule

// File: tb/tb_sync_pattern_serializer.sv
// Bench for sync_pattern_serializer: two instances (BIT_CYCLES=2 and 1) against a frame-level model.
module tb_sync_pattern_serializer;

`ifdef SYNC_PATTERN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 12 + PAR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in    [2];
  logic       data_valid [2];
  logic       data_ready [2];
  logic       out_s      [2];
  logic       bit_start  [2];
  logic       busy       [2];
  logic       frame_done [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_pattern_serializer #(
    .SYNC_W(4), .SYNC_PAT(4'b1011), .DATA_W(8), .BIT_CYCLES(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .data_in(data_in[0]), .data_valid(data_valid[0]),
    .data_ready(data_ready[0]), .out(out_s[0]), .bit_start(bit_start[0]),
    .busy(busy[0]), .frame_done(frame_done[0])
  );

  sync_pattern_serializer #(
    .SYNC_W(4), .SYNC_PAT(4'b1011), .DATA_W(8), .BIT_CYCLES(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .data_in(data_in[1]), .data_valid(data_valid[1]),
    .data_ready(data_ready[1]), .out(out_s[1]), .bit_start(bit_start[1]),
    .busy(busy[1]), .frame_done(frame_done[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bc(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [NB-1:0] build(input logic [7:0] v);
`ifdef SYNC_PATTERN_PARITY_EN
    return {4'b1011, v, ^v};
`else
    return {4'b1011, v};
`endif
  endfunction

  // Model: position within the frame in clock cycles (0 = idle, 1..len = in frame).
  int            m_t     [2] = '{0, 0};
  logic          m_ready [2] = '{1'b0, 1'b0};
  logic [NB-1:0] m_frame [2];

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_t[d]     <= 0;
        m_ready[d] <= 1'b0;
      end else if (m_t[d] == 0) begin
        if (m_ready[d] && data_valid[d]) begin
          m_frame[d] <= build(data_in[d]);
          m_t[d]     <= 1;
          m_ready[d] <= 1'b0;
        end else begin
          m_ready[d] <= 1'b1;
        end
      end else if (m_t[d] == NB * bc(d)) begin
        m_t[d]     <= 0;
        m_ready[d] <= 1'b1;
      end else begin
        m_t[d] <= m_t[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic e_out, e_bs, e_fd, e_busy;
    for (int d = 0; d < 2; d++) begin
      e_busy = (m_t[d] != 0);
      e_out  = 1'b0;
      e_bs   = 1'b0;
      if (e_busy) begin
        e_out = m_frame[d][NB - 1 - (m_t[d] - 1) / bc(d)];
        e_bs  = ((m_t[d] - 1) % bc(d)) == 0;
      end
      e_fd = (m_t[d] == NB * bc(d));
      check($sformatf("cyc_out[%0d]", d),        out_s[d],      e_out);
      check($sformatf("cyc_busy[%0d]", d),       busy[d],       e_busy);
      check($sformatf("cyc_bit_start[%0d]", d),  bit_start[d],  e_bs);
      check($sformatf("cyc_frame_done[%0d]", d), frame_done[d], e_fd);
      check($sformatf("cyc_data_ready[%0d]", d), data_ready[d], m_ready[d]);
    end
  end

  task automatic send(input int d, input logic [7:0] v, output int len,
                      output logic [63:0] stream, output int starts);
    int w;
    w = 0;
    @(posedge clk); #1;
    while (!data_ready[d] && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    data_in[d]    = v;
    data_valid[d] = 1'b1;
    @(posedge clk); #1;
    data_valid[d] = 1'b0;
    len    = 0;
    stream = '0;
    starts = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      stream = {stream[62:0], out_s[d]};
      if (bit_start[d]) starts++;
      if (frame_done[d]) begin
        len = c;
        break;
      end
    end
  endtask

  initial begin
    int          len, starts, gap, hits, pos, fd, busy_cnt;
    logic [63:0] stream;
    logic [3:0]  win;
    logic [63:0] exp_s;
    data_valid[0] = 1'b0; data_valid[1] = 1'b0;
    data_in[0]    = '0;   data_in[1]    = '0;
    #2 rst = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out",        out_s[0],      1'b0);
    check("rst_ready",      data_ready[0], 1'b0);
    check("rst_busy",       busy[0],       1'b0);
    check("rst_bit_start",  bit_start[0],  1'b0);
    check("rst_frame_done", frame_done[0], 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("ready_before_edge", data_ready[0], 1'b0);
    @(negedge clk);
    check("ready_after_edge_a", data_ready[0], 1'b1);
    check("ready_after_edge_b", data_ready[1], 1'b1);

    // A5 at two cycles per bit
    send(0, 8'hA5, len, stream, starts);
    check("t1_len",    len,    24 + 2 * PAR);
    check("t1_starts", starts, 12 + PAR);
    check("t1_stream", stream >> (2 * PAR), 64'hCFCC33);

    // back-to-back frames with valid held, one cycle per bit
    @(negedge clk);
    data_in[1] = 8'h3C; data_valid[1] = 1'b1;
    for (int c = 0; c < 10 && !busy[1]; c++) @(negedge clk);
    check("t2_first_busy", busy[1], 1'b1);
    data_in[1] = 8'hC3;
    for (int c = 0; c < 40 && !frame_done[1]; c++) @(negedge clk);
    check("t2_first_done", frame_done[1], 1'b1);
    gap = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy[1]) break;
      gap++;
    end
    check("t2_gap", gap, 1);
    data_valid[1] = 1'b0;
    for (int c = 0; c < 40 && !frame_done[1]; c++) @(negedge clk);
    check("t2_second_done", frame_done[1], 1'b1);

    // 1011 detector over the line with a zero payload
    send(1, 8'h00, len, stream, starts);
    check("t3_len", len, NB);
    hits = 0; pos = 0; win = '0;
    for (int c = 1; c <= len; c++) begin
      win = {win[2:0], stream[len - c]};
      if (c >= 4 && win == 4'b1011) begin
        hits++;
        pos = c;
      end
    end
    check("t3_hits", hits, 1);
    check("t3_pos",  pos,  4);

    // asynchronous reset during payload bit 3 (cycle 15 of the frame)
    @(posedge clk); #1;
    data_in[0] = 8'hF0; data_valid[0] = 1'b1;
    @(posedge clk); #1;
    data_valid[0] = 1'b0;
    fd = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (frame_done[0]) fd++;
    end
    @(negedge clk);
    check("t4_out_before", out_s[0], 1'b1);
    #3 rst = 1'b0;
    #1;
    check("t4_out_async",   out_s[0],      1'b0);
    check("t4_busy_async",  busy[0],       1'b0);
    check("t4_ready_async", data_ready[0], 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t4_ready_pre", data_ready[0], 1'b0);
    @(negedge clk);
    check("t4_ready_post", data_ready[0], 1'b1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (frame_done[0]) fd++;
    end
    check("t4_no_frame_done", fd, 0);

    // valid pulsed mid-frame is ignored
    @(posedge clk); #1;
    data_in[0] = 8'h5A; data_valid[0] = 1'b1;
    @(posedge clk); #1;
    data_valid[0] = 1'b0;
    len = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 4) begin data_in[0] = 8'hFF; data_valid[0] = 1'b1; end
      if (c == 5) data_valid[0] = 1'b0;
      if (frame_done[0]) begin
        len = c;
        break;
      end
    end
    check("t5_len", len, 24 + 2 * PAR);
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy[0]) busy_cnt++;
    end
    check("t5_no_second_frame", busy_cnt, 0);

    // frame length and last bit with payload 07
    send(0, 8'h07, len, stream, starts);
`ifdef SYNC_PATTERN_PARITY_EN
    exp_s = (64'hCF003F << 2) | 64'h3;
`else
    exp_s = 64'hCF003F;
`endif
    check("t6_len",      len,       24 + 2 * PAR);
    check("t6_starts",   starts,    12 + PAR);
    check("t6_last_bit", stream[0], 1'b1);
    check("t6_stream",   stream,    exp_s);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
